// File: rtl/layer_sequencer_fsm_if.sv
// Handshake bundle between the layer sequencer and the conv/pool/FC/judge engines.
// The master modport is the sequencer side; slave is the engines/host side.
interface layer_sequencer_fsm_if #(
  parameter int ADDRESS_DATAWIDTH = 13,
  parameter int FRAME_CNT_WIDTH   = 8
);
  logic [ADDRESS_DATAWIDTH-1:0] address;
  logic                         Conv_done;
  logic                         Avg_done;
  logic                         FC_done;
  logic                         Judge_done;
  logic                         clear_error;
  logic [2:0]                   state;
  logic [2:0]                   stage_idx;
  logic [1:0]                   conv_idx;
  logic                         conv_start;
  logic                         pool_start;
  logic                         fc_start;
  logic                         judge_start;
  logic                         busy;
  logic                         frame_done;
  logic                         error;
  logic [FRAME_CNT_WIDTH-1:0]   frame_count;

  modport master (
    input  address, Conv_done, Avg_done, FC_done, Judge_done, clear_error,
    output state, stage_idx, conv_idx, conv_start, pool_start, fc_start,
           judge_start, busy, frame_done, error, frame_count
  );

  modport slave (
    output address, Conv_done, Avg_done, FC_done, Judge_done, clear_error,
    input  state, stage_idx, conv_idx, conv_start, pool_start, fc_start,
           judge_start, busy, frame_done, error, frame_count
  );
endinterface

// File: rtl/layer_sequencer_fsm.sv
// Master sequencer for the detection network layer chain: arms on a completed frame
// load, then walks the conv/pool stages, FC and JUDGE under a per-phase watchdog.
module layer_sequencer_fsm #(
  parameter int NUM_STAGES        = 3,
  parameter int CONVS_PER_STAGE   = 2,
  parameter int INPUT_SIZE        = 80,
  parameter int ADDRESS_DATAWIDTH = 13,
  parameter int WDT_WIDTH         = 20,
  parameter int TIMEOUT_CYCLES    = 1000000,
  parameter int FRAME_CNT_WIDTH   = 8
) (
  input logic                   clk,
  input logic                   reset,
  layer_sequencer_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    POOL  = 3'd2,
    FC    = 3'd3,
    JUDGE = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam logic [ADDRESS_DATAWIDTH-1:0] LAST_ADDR  = ADDRESS_DATAWIDTH'(INPUT_SIZE*INPUT_SIZE-1);
  localparam logic [WDT_WIDTH-1:0]         WDT_LIMIT  = WDT_WIDTH'(TIMEOUT_CYCLES-1);
  localparam logic [2:0]                   LAST_STAGE = 3'(NUM_STAGES-1);
  localparam logic [1:0]                   LAST_CONV  = 2'(CONVS_PER_STAGE-1);

  state_t                     state_q, state_d;
  logic [2:0]                 stageIdx_q, stageIdx_d;
  logic [1:0]                 convIdx_q, convIdx_d;
  logic                       loaded_q, loaded_d;
  logic [WDT_WIDTH-1:0]       wdt_q, wdt_d;
  logic [3:0]                 doneHist_q;
  logic [3:0]                 doneIn, doneEvent;
  logic                       convStart_q, convStart_d;
  logic                       poolStart_q, poolStart_d;
  logic                       fcStart_q, fcStart_d;
  logic                       judgeStart_q, judgeStart_d;
  logic                       frameDone_q, frameDone_d;
  logic [FRAME_CNT_WIDTH-1:0] frameCount_q, frameCount_d;
  logic                       accepted;
  logic                       busy;

  // Bit order: 0 conv, 1 pool, 2 FC, 3 judge; only rising edges advance the chain.
  assign doneIn    = {bus.Judge_done, bus.FC_done, bus.Avg_done, bus.Conv_done};
  assign doneEvent = doneIn & ~doneHist_q;
  assign busy      = (state_q == CONV) || (state_q == POOL) ||
                     (state_q == FC)   || (state_q == JUDGE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      stageIdx_q   <= '0;
      convIdx_q    <= '0;
      loaded_q     <= 1'b0;
      wdt_q        <= '0;
      doneHist_q   <= '0;
      convStart_q  <= 1'b0;
      poolStart_q  <= 1'b0;
      fcStart_q    <= 1'b0;
      judgeStart_q <= 1'b0;
      frameDone_q  <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      stageIdx_q   <= stageIdx_d;
      convIdx_q    <= convIdx_d;
      loaded_q     <= loaded_d;
      wdt_q        <= wdt_d;
      doneHist_q   <= doneIn;
      convStart_q  <= convStart_d;
      poolStart_q  <= poolStart_d;
      fcStart_q    <= fcStart_d;
      judgeStart_q <= judgeStart_d;
      frameDone_q  <= frameDone_d;
      frameCount_q <= frameCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    stageIdx_d   = stageIdx_q;
    convIdx_d    = convIdx_q;
    loaded_d     = loaded_q;
    wdt_d        = '0;
    convStart_d  = 1'b0;
    poolStart_d  = 1'b0;
    fcStart_d    = 1'b0;
    judgeStart_d = 1'b0;
    frameDone_d  = 1'b0;
    frameCount_d = frameCount_q;
    accepted     = 1'b0;

    case (state_q)
      IDLE: begin
        // Arm on the write that follows the last pixel, so the frame is complete.
        if (loaded_q && (bus.address != LAST_ADDR)) begin
          state_d     = CONV;
          stageIdx_d  = '0;
          convIdx_d   = '0;
          convStart_d = 1'b1;
          loaded_d    = 1'b0;
        end else if (bus.address == LAST_ADDR) begin
          loaded_d = 1'b1;
        end
      end
      CONV: begin
        if (doneEvent[0]) begin
          accepted = 1'b1;
          if (convIdx_q < LAST_CONV) begin
            convIdx_d   = convIdx_q + 2'd1;
            convStart_d = 1'b1;
          end else begin
            state_d     = POOL;
            poolStart_d = 1'b1;
          end
        end
      end
      POOL: begin
        if (doneEvent[1]) begin
          accepted = 1'b1;
          if (stageIdx_q < LAST_STAGE) begin
            stageIdx_d  = stageIdx_q + 3'd1;
            convIdx_d   = '0;
            state_d     = CONV;
            convStart_d = 1'b1;
          end else begin
            state_d   = FC;
            fcStart_d = 1'b1;
          end
        end
      end
      FC: begin
        if (doneEvent[2]) begin
          accepted     = 1'b1;
          state_d      = JUDGE;
          judgeStart_d = 1'b1;
        end
      end
      JUDGE: begin
        if (doneEvent[3]) begin
          accepted     = 1'b1;
          state_d      = IDLE;
          frameDone_d  = 1'b1;
          frameCount_d = frameCount_q + FRAME_CNT_WIDTH'(1);
          stageIdx_d   = '0;
          convIdx_d    = '0;
        end
      end
      ERROR: begin
        if (bus.clear_error) begin
          state_d    = IDLE;
          stageIdx_d = '0;
          convIdx_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A done event in the terminal-count cycle wins; indices stay put for debug.
    if (busy) begin
      if (accepted) begin
        wdt_d = '0;
      end else if (wdt_q == WDT_LIMIT) begin
        state_d = ERROR;
        wdt_d   = '0;
      end else begin
        wdt_d = wdt_q + WDT_WIDTH'(1);
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.stage_idx   = stageIdx_q;
  assign bus.conv_idx    = convIdx_q;
  assign bus.conv_start  = convStart_q;
  assign bus.pool_start  = poolStart_q;
  assign bus.fc_start    = fcStart_q;
  assign bus.judge_start = judgeStart_q;
  assign bus.busy        = busy;
  assign bus.frame_done  = frameDone_q;
  assign bus.error       = (state_q == ERROR);
  assign bus.frame_count = frameCount_q;

endmodule
